// File: rtl/ex_ula.sv
// ex_ula -- execute-stage ALU.
// Single-cycle ops (ADD, SUB, logic, shifts, SLT) register their result on the
// accept edge. MUL runs a 16-iteration shift-add sequence and holds off new
// requests (pronto=0) until the product is written.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   valido_in               request from decode
//   A, B, constanteExtendida operands; sel_B picks B (0) or immediate (1)
//   op_ULA                  operation code
//   pronto                  request can be accepted this cycle
//   resultado_ULA           registered result
//   valido_out              one-cycle pulse per new result
//   flags                   registered {Z,N,C,V}
module ex_ula (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valido_in,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] constanteExtendida,
    input  logic        sel_B,
    input  logic [3:0]  op_ULA,
    output logic        pronto,
    output logic [15:0] resultado_ULA,
    output logic        valido_out,
    output logic [3:0]  flags
);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                           OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NOT = 4'd5,
                           OP_PAS = 4'd6,  OP_SHL = 4'd7,  OP_SHR = 4'd8,
                           OP_SAR = 4'd9,  OP_MUL = 4'd10, OP_SLT = 4'd11;

    typedef enum logic {OCIOSO = 1'b0, MULTIPLICA = 1'b1} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_result, r_mcand, r_mplier, r_acc;
    logic [3:0]  r_flags, r_cnt;
    logic        r_vld;

    logic        w_accept, w_last;
    logic [15:0] w_op2, w_res, w_acc_nxt;
    logic        w_c, w_v, w_upd;
    logic [3:0]  w_amt;
    logic [16:0] w_sum, w_dif, w_shl, w_shr;
    logic signed [16:0] w_sar;

    assign w_op2    = sel_B ? constanteExtendida : B;
    assign w_amt    = w_op2[3:0];
    assign w_accept = valido_in & pronto;
    assign w_last   = (r_state == MULTIPLICA) && (r_cnt == 4'd15);

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= OCIOSO;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            OCIOSO:     if (w_accept && op_ULA == OP_MUL) w_next = MULTIPLICA;
            MULTIPLICA: if (w_last) w_next = OCIOSO;
            default:    w_next = OCIOSO;
        endcase
    end

    always_comb begin
        pronto = (r_state == OCIOSO);
    end

    // ---------------- single-cycle ALU ----------------
    // Shifts are done one bit wider so the last bit shifted out lands in the
    // extra position; an amount of 0 leaves that position at 0.
    assign w_sum = {1'b0, A} + {1'b0, w_op2};
    assign w_dif = {1'b0, A} - {1'b0, w_op2};
    assign w_shl = {1'b0, A} << w_amt;
    assign w_shr = {A, 1'b0} >> w_amt;
    assign w_sar = $signed({A, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = 16'd0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b1;
        case (op_ULA)
            OP_ADD: begin
                w_res = w_sum[15:0];
                w_c   = w_sum[16];
                w_v   = (A[15] == w_op2[15]) && (w_sum[15] != A[15]);
            end
            OP_SUB: begin
                w_res = w_dif[15:0];
                w_c   = w_dif[16];  // borrow
                w_v   = (A[15] != w_op2[15]) && (w_dif[15] != A[15]);
            end
            OP_AND: w_res = A & w_op2;
            OP_OR:  w_res = A | w_op2;
            OP_XOR: w_res = A ^ w_op2;
            OP_NOT: w_res = ~A;
            OP_PAS: w_res = w_op2;
            OP_SHL: begin
                w_res = w_shl[15:0];
                w_c   = w_shl[16];
            end
            OP_SHR: begin
                w_res = w_shr[16:1];
                w_c   = w_shr[0];
            end
            OP_SAR: begin
                w_res = w_sar[16:1];
                w_c   = w_sar[0];
            end
            OP_SLT: w_res = {15'd0, $signed(A) < $signed(w_op2)};
            OP_MUL: w_upd = 1'b0;   // handled by the iterative path
            default: w_upd = 1'b0;  // reserved: result 0, flags kept
        endcase
    end

    // ---------------- shift-add multiplier ----------------
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= 16'd0;
            r_flags  <= 4'd0;
            r_vld    <= 1'b0;
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_acc    <= 16'd0;
            r_cnt    <= 4'd0;
        end else begin
            r_vld <= 1'b0;
            if (w_accept) begin
                if (op_ULA == OP_MUL) begin
                    // Operands are captured here so later input changes
                    // cannot disturb the product.
                    r_mcand  <= A;
                    r_mplier <= w_op2;
                    r_acc    <= 16'd0;
                    r_cnt    <= 4'd0;
                end else begin
                    r_result <= w_res;
                    r_vld    <= 1'b1;
                    if (w_upd)
                        r_flags <= {w_res == 16'd0, w_res[15], w_c, w_v};
                end
            end else if (r_state == MULTIPLICA) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 4'd1;
                if (w_last) begin
                    r_result <= w_acc_nxt;
                    r_flags  <= {w_acc_nxt == 16'd0, w_acc_nxt[15], 2'b00};
                    r_vld    <= 1'b1;
                end
            end
        end
    end

    assign resultado_ULA = r_result;
    assign flags         = r_flags;
    assign valido_out    = r_vld;

endmodule

// File: tb/tb_ex_ula.sv
// Directed bench for ex_ula: reset state, every opcode, flag corner cases,
// back-to-back issue, iterative multiply with input disturbance, and reset
// in the middle of a multiply.
module tb_ex_ula;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valido_in = 1'b0;
    logic [15:0] A = 16'd0, B = 16'd0, constanteExtendida = 16'd0;
    logic        sel_B = 1'b0;
    logic [3:0]  op_ULA = 4'd0;
    logic        pronto;
    logic [15:0] resultado_ULA;
    logic        valido_out;
    logic [3:0]  flags;

    int n_chk = 0;
    int n_err = 0;

    ex_ula dut (
        .clock(clock), .reset_n(reset_n), .valido_in(valido_in),
        .A(A), .B(B), .constanteExtendida(constanteExtendida),
        .sel_B(sel_B), .op_ULA(op_ULA), .pronto(pronto),
        .resultado_ULA(resultado_ULA), .valido_out(valido_out), .flags(flags)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at the falling edge, sample 1 time unit after the rising edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] k,
                         input logic s, input logic [3:0] op);
        @(negedge clock);
        A = a; B = b; constanteExtendida = k; sel_B = s; op_ULA = op; valido_in = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic idle();
        @(negedge clock);
        valido_in = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic op_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] k, input logic s, input logic [3:0] op,
                          input logic [15:0] res, input logic [3:0] fl);
        issue(a, b, k, s, op);
        chk({tag, ".res"}, resultado_ULA, res);
        chk({tag, ".flags"}, {12'd0, flags}, {12'd0, fl});
        chk({tag, ".vld"}, {15'd0, valido_out}, 16'd1);
    endtask

    // Wait out a multiply already accepted; 15 busy edges then the final one.
    task automatic mul_finish(input string tag, input logic [15:0] res, input logic [3:0] fl);
        @(negedge clock);
        valido_in = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        chk({tag, ".busy"}, {15'd0, pronto}, 16'd0);
        @(posedge clock); #1;
        chk({tag, ".res"}, resultado_ULA, res);
        chk({tag, ".flags"}, {12'd0, flags}, {12'd0, fl});
        chk({tag, ".vld"}, {15'd0, valido_out}, 16'd1);
        chk({tag, ".pronto"}, {15'd0, pronto}, 16'd1);
    endtask

    initial begin
        // ---- reset state ----
        #12;
        chk("rst.res", resultado_ULA, 16'h0000);
        chk("rst.flags", {12'd0, flags}, 16'h0000);
        chk("rst.vld", {15'd0, valido_out}, 16'd0);
        chk("rst.pronto", {15'd0, pronto}, 16'd1);

        // ---- first accept on the first edge after release: ADD overflow ----
        @(negedge clock);
        reset_n = 1'b1;
        A = 16'h7FFF; B = 16'h0001; sel_B = 1'b0; op_ULA = 4'd0; valido_in = 1'b1;
        @(posedge clock); #1;
        chk("add_ovf.res", resultado_ULA, 16'h8000);
        chk("add_ovf.flags", {12'd0, flags}, 16'b0101);
        chk("add_ovf.vld", {15'd0, valido_out}, 16'd1);

        // ---- idle with garbage inputs: outputs hold, pulse drops ----
        @(negedge clock);
        valido_in = 1'b0; A = 16'h1111; B = 16'h2222; op_ULA = 4'd4;
        @(posedge clock); #1;
        chk("idle.vld", {15'd0, valido_out}, 16'd0);
        chk("idle.res", resultado_ULA, 16'h8000);
        chk("idle.flags", {12'd0, flags}, 16'b0101);

        // ---- SUB with immediate, then reserved ops keep flags ----
        op_chk("sub_imm", 16'h0003, 16'h9999, 16'h0005, 1'b1, 4'd1, 16'hFFFE, 4'b0110);
        op_chk("rsv13", 16'h1234, 16'h5678, 16'h0000, 1'b0, 4'd13, 16'h0000, 4'b0110);
        op_chk("rsv15", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 4'd15, 16'h0000, 4'b0110);

        // ---- back-to-back ADD then SHL ----
        op_chk("b2b_add", 16'h8001, 16'h0001, 16'h0000, 1'b0, 4'd0, 16'h8002, 4'b0100);
        op_chk("b2b_shl", 16'h8001, 16'h0001, 16'h0000, 1'b0, 4'd7, 16'h0002, 4'b0010);

        // ---- MUL with operand disturbance during the iterations ----
        issue(16'h0123, 16'h0010, 16'h0000, 1'b0, 4'd10);
        chk("mul.acc_pronto", {15'd0, pronto}, 16'd0);
        chk("mul.acc_vld", {15'd0, valido_out}, 16'd0);
        chk("mul.acc_hold", resultado_ULA, 16'h0002);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            A = 16'(i * 16'h0101);
            B = i[0] ? 16'hFFFF : 16'h0000;
            constanteExtendida = 16'h00FF;
            sel_B = i[1];
            op_ULA = 4'd0;
            valido_in = (i < 16) ? i[0] : 1'b0;
            @(posedge clock); #1;
            if (i < 16) begin
                chk($sformatf("mul.busy%0d", i), {15'd0, pronto}, 16'd0);
                chk($sformatf("mul.novld%0d", i), {15'd0, valido_out}, 16'd0);
            end
        end
        chk("mul.res", resultado_ULA, 16'h1230);
        chk("mul.flags", {12'd0, flags}, 16'b0000);
        chk("mul.vld", {15'd0, valido_out}, 16'd1);
        chk("mul.pronto", {15'd0, pronto}, 16'd1);
        idle();
        chk("mul.after_vld", {15'd0, valido_out}, 16'd0);
        chk("mul.after_res", resultado_ULA, 16'h1230);

        // ---- remaining opcodes, issued every cycle ----
        op_chk("and", 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 4'd2, 16'h00F0, 4'b0000);
        op_chk("or", 16'hF000, 16'h000F, 16'h0000, 1'b0, 4'd3, 16'hF00F, 4'b0100);
        op_chk("xor", 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 4'd4, 16'h0000, 4'b1000);
        op_chk("not", 16'h00FF, 16'h0000, 16'h0000, 1'b0, 4'd5, 16'hFF00, 4'b0100);
        op_chk("pass", 16'h5555, 16'h0000, 16'h1234, 1'b1, 4'd6, 16'h1234, 4'b0000);
        op_chk("shr", 16'h8001, 16'h0001, 16'h0000, 1'b0, 4'd8, 16'h4000, 4'b0010);
        op_chk("sar4", 16'h8000, 16'h0004, 16'h0000, 1'b0, 4'd9, 16'hF800, 4'b0100);
        op_chk("shl0", 16'h1234, 16'h0010, 16'h0000, 1'b0, 4'd7, 16'h1234, 4'b0000);
        op_chk("slt_t", 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 4'd11, 16'h0001, 4'b0000);
        op_chk("slt_f", 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 4'd11, 16'h0000, 4'b1000);
        op_chk("sub_pos", 16'h0005, 16'h0003, 16'h0000, 1'b0, 4'd1, 16'h0002, 4'b0000);
        op_chk("sub_ovf", 16'h8000, 16'h0001, 16'h0000, 1'b0, 4'd1, 16'h7FFF, 4'b0001);
        op_chk("add_zc", 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'b1010);

        // ---- MUL with immediate operand, negative product ----
        issue(16'hFFFF, 16'h0000, 16'h0003, 1'b1, 4'd10);
        mul_finish("mul_neg", 16'hFFFD, 4'b0100);

        // ---- reset in the middle of a multiply ----
        op_chk("sar1", 16'h8001, 16'h0001, 16'h0000, 1'b0, 4'd9, 16'hC000, 4'b0110);
        issue(16'h0123, 16'h0010, 16'h0000, 1'b0, 4'd10);
        @(negedge clock);
        valido_in = 1'b0;
        repeat (7) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst.res", resultado_ULA, 16'h0000);
        chk("midrst.flags", {12'd0, flags}, 16'h0000);
        chk("midrst.vld", {15'd0, valido_out}, 16'd0);
        chk("midrst.pronto", {15'd0, pronto}, 16'd1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            chk($sformatf("midrst.quiet%0d", i), {15'd0, valido_out}, 16'd0);
        end
        chk("midrst.pronto_after", {15'd0, pronto}, 16'd1);
        op_chk("add_after_rst", 16'h0002, 16'h0003, 16'h0000, 1'b0, 4'd0, 16'h0005, 4'b0000);
        idle();
        chk("end.vld", {15'd0, valido_out}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
